// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer state encodings, IR field positions
// and the next-PC source select.
package cpu_pkg;

  localparam int OPCODE_MSB    = 15;
  localparam int OPCODE_LSB    = 12;
  localparam int JUMP_MSB      = 11;
  localparam int BR_OFFSET_MSB = 7;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_t;

  function automatic logic [15:0] sext_offset(input logic [BR_OFFSET_MSB:0] off);
    return {{(15 - BR_OFFSET_MSB){off[BR_OFFSET_MSB]}}, off};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: increment, in-page jump, or zero-conditional relative branch.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] ir,
  input  pc_sel_t     sel,
  input  logic        zero_flag,
  output logic [15:0] pc_next
);

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:    pc_next = pc + 16'd1;
      PC_JUMP:   pc_next = {pc[15:JUMP_MSB+1], ir[JUMP_MSB:0]};
      // pc already points past the branch, so the offset is relative to PC+1
      PC_BRANCH: pc_next = zero_flag ? pc + sext_offset(ir[BR_OFFSET_MSB:0]) : pc;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback/halt
// with PC and IR ownership and one-cycle write strobes.
module fetch_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata_in,
  input  logic [15:0] alu_result_in,
  input  logic        alu_zero_flag_in,
  input  logic        reg_write_enable_in,
  input  logic        mem_write_enable_in,
  input  logic        mem_to_reg_select_in,
  input  logic        jump_enable_in,
  input  logic        branch_enable_in,
  input  logic        mem_address_select_in,
  input  logic        halt_cpu_in,
  output logic [3:0]  opcode_out,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] mem_addr_out,
  output logic        mem_write_strobe_out,
  output logic        reg_write_strobe_out,
  output logic        wb_from_mem_out,
  output logic        halted_out,
  output logic [2:0]  state_out
);

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] ir_reg;
  logic        mem_we_latch_reg;
  logic        reg_we_latch_reg;
  logic        mem_to_reg_latch_reg;
  logic        mem_write_strobe_reg;
  logic        reg_write_strobe_reg;
  logic        halted_reg;

  pc_sel_t     pc_sel;
  logic [15:0] pc_next;

  always_comb begin
    pc_sel = PC_INC;
    if (state_reg == ST_EXECUTE) begin
      pc_sel = jump_enable_in ? PC_JUMP : PC_BRANCH;
    end
  end

  pc_next_calc u_pc_next_calc (
    .pc        (pc_reg),
    .ir        (ir_reg),
    .sel       (pc_sel),
    .zero_flag (alu_zero_flag_in),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= ST_FETCH;
      pc_reg               <= 16'h0000;
      ir_reg               <= 16'h0000;
      mem_we_latch_reg     <= 1'b0;
      reg_we_latch_reg     <= 1'b0;
      mem_to_reg_latch_reg <= 1'b0;
      mem_write_strobe_reg <= 1'b0;
      reg_write_strobe_reg <= 1'b0;
      halted_reg           <= 1'b0;
    end else begin
      // strobes are set only on the edge entering the state they belong to
      mem_write_strobe_reg <= 1'b0;
      reg_write_strobe_reg <= 1'b0;
      case (state_reg)
        ST_FETCH: state_reg <= ST_DECODE;
        ST_DECODE: begin
          ir_reg    <= mem_rdata_in;
          pc_reg    <= pc_next;
          state_reg <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          mem_we_latch_reg     <= mem_write_enable_in;
          reg_we_latch_reg     <= reg_write_enable_in;
          mem_to_reg_latch_reg <= mem_to_reg_select_in;
          if (halt_cpu_in) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else if (jump_enable_in || branch_enable_in) begin
            pc_reg    <= pc_next;
            state_reg <= ST_FETCH;
          end else if (mem_address_select_in) begin
            mem_write_strobe_reg <= mem_write_enable_in;
            state_reg            <= ST_MEMORY;
          end else if (reg_write_enable_in) begin
            reg_write_strobe_reg <= 1'b1;
            state_reg            <= ST_WRITEBACK;
          end else begin
            state_reg <= ST_FETCH;
          end
        end
        ST_MEMORY: begin
          if (!mem_we_latch_reg && reg_we_latch_reg) begin
            reg_write_strobe_reg <= 1'b1;
            state_reg            <= ST_WRITEBACK;
          end else begin
            state_reg <= ST_FETCH;
          end
        end
        ST_WRITEBACK: state_reg <= ST_FETCH;
        ST_HALT:      state_reg <= ST_HALT;
        default:      state_reg <= ST_FETCH;
      endcase
    end
  end

  assign opcode_out           = ir_reg[OPCODE_MSB:OPCODE_LSB];
  assign instr_out            = ir_reg;
  assign pc_out               = pc_reg;
  assign mem_addr_out         = (state_reg == ST_MEMORY) ? alu_result_in : pc_reg;
  assign mem_write_strobe_out = mem_write_strobe_reg;
  assign reg_write_strobe_out = reg_write_strobe_reg;
  assign wb_from_mem_out      = (state_reg == ST_WRITEBACK) && mem_to_reg_latch_reg;
  assign halted_out           = halted_reg;
  assign state_out            = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized instruction-level bench for fetch_sequencer with a class-based reference model.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  localparam int CLS_NOP  = 0;
  localparam int CLS_ALU  = 1;
  localparam int CLS_LD   = 2;
  localparam int CLS_ST   = 3;
  localparam int CLS_BEQZ = 4;
  localparam int CLS_JMP  = 5;
  localparam int CLS_HLT  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] mem_rdata_in = '0;
  logic [15:0] alu_result_in = '0;
  logic        alu_zero_flag_in = 1'b0;
  logic        reg_write_enable_in = 1'b0;
  logic        mem_write_enable_in = 1'b0;
  logic        mem_to_reg_select_in = 1'b0;
  logic        jump_enable_in = 1'b0;
  logic        branch_enable_in = 1'b0;
  logic        mem_address_select_in = 1'b0;
  logic        halt_cpu_in = 1'b0;
  logic [3:0]  opcode_out;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] mem_addr_out;
  logic        mem_write_strobe_out;
  logic        reg_write_strobe_out;
  logic        wb_from_mem_out;
  logic        halted_out;
  logic [2:0]  state_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] pc_model = '0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_rdata_in          (mem_rdata_in),
    .alu_result_in         (alu_result_in),
    .alu_zero_flag_in      (alu_zero_flag_in),
    .reg_write_enable_in   (reg_write_enable_in),
    .mem_write_enable_in   (mem_write_enable_in),
    .mem_to_reg_select_in  (mem_to_reg_select_in),
    .jump_enable_in        (jump_enable_in),
    .branch_enable_in      (branch_enable_in),
    .mem_address_select_in (mem_address_select_in),
    .halt_cpu_in           (halt_cpu_in),
    .opcode_out            (opcode_out),
    .instr_out             (instr_out),
    .pc_out                (pc_out),
    .mem_addr_out          (mem_addr_out),
    .mem_write_strobe_out  (mem_write_strobe_out),
    .reg_write_strobe_out  (reg_write_strobe_out),
    .wb_from_mem_out       (wb_from_mem_out),
    .halted_out            (halted_out),
    .state_out             (state_out)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycle count and state visited per instruction class.
  function automatic int n_cycles(input int cls);
    case (cls)
      CLS_ALU, CLS_ST: return 4;
      CLS_LD:          return 5;
      default:         return 3;
    endcase
  endfunction

  function automatic int state_at(input int cls, input int k);
    if (k < 3) return k;
    if (cls == CLS_ALU) return 4;
    return (k == 3) ? 3 : 4;
  endfunction

  function automatic logic [15:0] next_pc(input int cls, input logic [15:0] pc,
                                          input logic [15:0] ir, input logic zero);
    int p1;
    int off;
    p1 = (int'(pc) + 1) % 65536;
    if (cls == CLS_JMP) return 16'((p1 / 4096) * 4096 + int'(ir) % 4096);
    if (cls == CLS_BEQZ && zero) begin
      off = int'(ir) % 256;
      if (off >= 128) off = off - 256;
      return 16'((p1 + off + 65536) % 65536);
    end
    return 16'(p1);
  endfunction

  function automatic logic [15:0] make_ir(input int cls);
    logic [3:0] op;
    case (cls)
      CLS_ALU:  op = 4'($urandom_range(1, 5));
      CLS_LD:   op = OP_LD;
      CLS_ST:   op = OP_ST;
      CLS_BEQZ: op = OP_BEQZ;
      CLS_JMP:  op = OP_JMP;
      CLS_HLT:  op = OP_HLT;
      default:  op = OP_NOP;
    endcase
    return {op, 12'($urandom)};
  endfunction

  task automatic drive_noise();
    mem_rdata_in          = 16'($urandom);
    alu_result_in         = 16'($urandom);
    alu_zero_flag_in      = 1'($urandom);
    reg_write_enable_in   = 1'($urandom);
    mem_write_enable_in   = 1'($urandom);
    mem_to_reg_select_in  = 1'($urandom);
    jump_enable_in        = 1'($urandom);
    branch_enable_in      = 1'($urandom);
    mem_address_select_in = 1'($urandom);
    halt_cpu_in           = 1'($urandom);
  endtask

  // Acts as the control unit; lower-priority enables get random noise where they must lose.
  task automatic drive_controls(input int cls, input logic zero);
    alu_zero_flag_in      = zero;
    halt_cpu_in           = 1'b0;
    jump_enable_in        = 1'b0;
    branch_enable_in      = 1'b0;
    mem_address_select_in = 1'b0;
    reg_write_enable_in   = 1'b0;
    mem_write_enable_in   = 1'b0;
    mem_to_reg_select_in  = 1'b0;
    case (cls)
      CLS_ALU: reg_write_enable_in = 1'b1;
      CLS_LD: begin
        mem_address_select_in = 1'b1;
        reg_write_enable_in   = 1'b1;
        mem_to_reg_select_in  = 1'b1;
      end
      CLS_ST: begin
        mem_address_select_in = 1'b1;
        mem_write_enable_in   = 1'b1;
      end
      CLS_BEQZ: begin
        branch_enable_in      = 1'b1;
        mem_address_select_in = 1'($urandom);
        reg_write_enable_in   = 1'($urandom);
        mem_write_enable_in   = 1'($urandom);
      end
      CLS_JMP: begin
        jump_enable_in        = 1'b1;
        branch_enable_in      = 1'($urandom);
        mem_address_select_in = 1'($urandom);
        reg_write_enable_in   = 1'($urandom);
      end
      CLS_HLT: begin
        halt_cpu_in           = 1'b1;
        jump_enable_in        = 1'($urandom);
        branch_enable_in      = 1'($urandom);
        reg_write_enable_in   = 1'($urandom);
        mem_write_enable_in   = 1'($urandom);
      end
      default: ;
    endcase
  endtask

  // Called at a negedge in FETCH; returns at the negedge of the next FETCH (or first HALT cycle).
  task automatic run_instr(input int cls, input logic [15:0] ir, input logic zero,
                           input logic [15:0] alu);
    int          n;
    int          st;
    logic [15:0] pc_start;
    logic [15:0] pc_inc;
    logic [15:0] pc_exp;
    n        = n_cycles(cls);
    pc_start = pc_model;
    pc_inc   = next_pc(CLS_NOP, pc_start, ir, 1'b0);
    for (int k = 0; k < n; k++) begin
      st = state_at(cls, k);
      drive_noise();
      if (k == 1) mem_rdata_in = ir;
      if (k == 2) drive_controls(cls, zero);
      if (st == 3) alu_result_in = alu;
      #1;
      pc_exp = (k < 2) ? pc_start : pc_inc;
      check("state", 16'(state_out), 16'(st));
      check("halted", 16'(halted_out), 16'h0);
      check("pc", pc_out, pc_exp);
      check("mem_addr", mem_addr_out, (st == 3) ? alu : pc_exp);
      check("mem_wr_strobe", 16'(mem_write_strobe_out), 16'(st == 3 && cls == CLS_ST));
      check("reg_wr_strobe", 16'(reg_write_strobe_out), 16'(st == 4));
      if (st == 4) check("wb_from_mem", 16'(wb_from_mem_out), 16'(cls == CLS_LD));
      if (k >= 2) begin
        check("instr", instr_out, ir);
        check("opcode", 16'(opcode_out), 16'(ir[15:12]));
      end
      @(negedge clk);
    end
    pc_model = next_pc(cls, pc_start, ir, zero);
    $display("instr cls=%0d ir=%04h zero=%0d pc %04h -> %04h", cls, ir, zero, pc_start, pc_model);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 16'(state_out), 16'h0);
    check({tag, "_pc"}, pc_out, 16'h0000);
    check({tag, "_instr"}, instr_out, 16'h0000);
    check({tag, "_opcode"}, 16'(opcode_out), 16'h0);
    check({tag, "_mem_wr"}, 16'(mem_write_strobe_out), 16'h0);
    check({tag, "_reg_wr"}, 16'(reg_write_strobe_out), 16'h0);
    check({tag, "_halted"}, 16'(halted_out), 16'h0);
    check({tag, "_mem_addr"}, mem_addr_out, 16'h0000);
  endtask

  // Page-climbing: JMP to xFFF then NOP rolls PC into the next 4K page.
  task automatic climb_to(input logic [15:0] target);
    for (int i = 0; i < 40 && pc_model != target; i++) begin
      run_instr(CLS_JMP, 16'hBFFF, 1'b0, 16'h0);
      if (pc_model != target) run_instr(CLS_NOP, 16'h0000, 1'b0, 16'h0);
    end
    check("climb", pc_out, target);
  endtask

  initial begin
    logic [15:0] ir;
    int          cls;

    drive_noise();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("held_rst");
    @(negedge clk);
    rst_n    = 1'b1;
    pc_model = 16'h0000;

    // ADD at address 0 goes through writeback
    run_instr(CLS_ALU, 16'h1123, 1'b0, 16'h0);
    check("add_pc", pc_out, 16'h0001);
    repeat (3) run_instr(CLS_NOP, 16'h0000, 1'b0, 16'h0);
    check("ld_pc", pc_out, 16'h0004);
    run_instr(CLS_LD, 16'h8345, 1'b0, 16'h0040);

    run_instr(CLS_JMP, 16'hB010, 1'b0, 16'h0);
    check("jmp_0010", pc_out, 16'h0010);
    run_instr(CLS_BEQZ, 16'hA0FE, 1'b1, 16'h0);
    check("beqz_taken", pc_out, 16'h000F);
    run_instr(CLS_JMP, 16'hB010, 1'b0, 16'h0);
    run_instr(CLS_BEQZ, 16'hA0FE, 1'b0, 16'h0);
    check("beqz_not_taken", pc_out, 16'h0011);

    climb_to(16'h5000);
    run_instr(CLS_JMP, 16'hB123, 1'b0, 16'h0);
    check("jmp_5123", pc_out, 16'h5123);

    climb_to(16'hF000);
    run_instr(CLS_JMP, 16'hBFFF, 1'b0, 16'h0);
    check("pc_ffff", pc_out, 16'hFFFF);
    run_instr(CLS_NOP, 16'h0000, 1'b0, 16'h0);
    check("pc_wrap", pc_out, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(CLS_NOP, CLS_JMP);
      ir  = make_ir(cls);
      run_instr(cls, ir, 1'($urandom), 16'($urandom));
    end

    // ST abandoned by reset during EXECUTE
    drive_noise();
    #1 check("st_rst_fetch", 16'(state_out), 16'h0);
    @(negedge clk);
    drive_noise();
    mem_rdata_in = 16'h9ABC;
    #1 check("st_rst_decode", 16'(state_out), 16'h1);
    @(negedge clk);
    drive_controls(CLS_ST, 1'b0);
    #1 check("st_rst_execute", 16'(state_out), 16'h2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("st_rst");
    @(posedge clk);
    #1 check("st_rst_no_strobe", 16'(mem_write_strobe_out), 16'h0);
    check("st_rst_state", 16'(state_out), 16'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    pc_model = 16'h0000;
    run_instr(CLS_NOP, 16'h0000, 1'b0, 16'h0);
    check("after_rst_pc", pc_out, 16'h0001);
    run_instr(CLS_ALU, make_ir(CLS_ALU), 1'b0, 16'h0);

    // HLT then a frozen core for 20 cycles
    ir = make_ir(CLS_HLT);
    run_instr(CLS_HLT, ir, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      drive_noise();
      #1;
      check("halt_state", 16'(state_out), 16'h5);
      check("halt_flag", 16'(halted_out), 16'h1);
      check("halt_pc", pc_out, pc_model);
      check("halt_instr", instr_out, ir);
      check("halt_mem_wr", 16'(mem_write_strobe_out), 16'h0);
      check("halt_reg_wr", 16'(reg_write_strobe_out), 16'h0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
